ifetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the CPU's instruction input. It drives sequential reads into the synchronous instruction memory, buffers the returned words in a small FIFO, and presents one instruction per cycle to the CPU's `i_datain` with a valid/ready handshake. When the queue is empty it emits NOP. A redirect from the CPU (branch/jump taken) flushes the buffered words and any in-flight read, then restarts fetching at the target.

---
 rtl/ifetch_queue.sv | 88 ++++++++
 tb/tb_ifetch_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch FIFO between synchronous instruction memory and the CPU
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW = 8,
    parameter int DW = 16,
    parameter logic [DW-1:0] NOP_WORD = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    output logic [DW-1:0] i_datain,
    output logic [AW-1:0] i_pc,
    output logic          i_valid,
    input  logic          i_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    fetch_pc;
    logic [DW+AW-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             inflight;
    logic [AW-1:0]    inflight_pc;
    logic             kill;
    logic             issue;
    logic             push;
    logic             pop;
    logic [DW+AW-1:0] head;

    // Issue credit counts buffered plus outstanding words so a returning read always has a slot
    always_comb begin
        issue = !reset && enable && !redirect && (count + CW'(inflight)) < CW'(DEPTH);
        push = inflight && !kill && !redirect;
        head = mem[rd_ptr];
        i_valid = !reset && count != '0;
        pop = i_valid && i_ready && !redirect;
        i_datain = i_valid ? head[DW+AW-1:AW] : NOP_WORD;
        i_pc = i_valid ? head[AW-1:0] : (reset ? '0 : fetch_pc);
        imem_rd = issue;
        imem_addr = reset ? '0 : fetch_pc;
    end

    // Returned words land at the tail tagged with the address they were fetched from
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {imem_data, inflight_pc};
    end

    // Fetch pointer, FIFO bookkeeping and the read-tracking flags; redirect wins over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            inflight <= 1'b0;
            inflight_pc <= '0;
            kill <= 1'b0;
        end else begin
            assert (!(push && !pop && count == CW'(DEPTH)));
            if (redirect) begin
                fetch_pc <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + AW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
            inflight <= issue;
            if (issue)
                inflight_pc <= fetch_pc;
            kill <= redirect || (kill && !issue);
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenario checks for the instruction prefetch queue
module tb_ifetch_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        i_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'hDEAD;
    logic [15:0] i_datain;
    logic [7:0]  i_pc;
    logic        i_valid;
    int checks = 0;
    int errors = 0;

    ifetch_queue dut (
        .clock(clock), .reset(reset), .enable(enable),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .i_datain(i_datain), .i_pc(i_pc), .i_valid(i_valid), .i_ready(i_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    // Synchronous memory model: word at address k is 16'h1000 + k, garbage when not read
    always @(posedge clock)
        imem_data <= imem_rd ? 16'h1000 + {8'h00, imem_addr} : 16'hDEAD;

    task automatic nxt;
        @(negedge clock);
        #1;
    endtask

    task automatic start(input logic en, input logic rdy);
        @(negedge clock);
        reset = 1'b1; enable = en; i_ready = rdy; redirect = 1'b0; redirect_pc = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1; enable = 1'b1; i_ready = 1'b1; redirect = 1'b0;
        #1;
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", imem_rd); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", imem_addr); end
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", i_valid); end
        checks++; if (i_datain !== 16'h0000) begin errors++; $display("FAIL reset_datain got %h exp 0000", i_datain); end
        checks++; if (i_pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", i_pc); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL first_issue got rd=%b addr=%h exp rd=1 addr=00", imem_rd, imem_addr); end
    endtask

    task automatic test_stream;
        start(1'b1, 1'b1);
        nxt();
        checks++; if (i_valid !== 1'b0 || imem_addr !== 8'h01) begin errors++; $display("FAIL stream_c2 got valid=%b addr=%h exp valid=0 addr=01", i_valid, imem_addr); end
        for (int k = 0; k < 6; k++) begin
            nxt();
            checks++; if (i_valid !== 1'b1 || i_datain !== 16'h1000 + 16'(k) || i_pc !== 8'(k))
                begin errors++; $display("FAIL stream k=%0d got v=%b d=%h pc=%h exp v=1 d=%h pc=%h", k, i_valid, i_datain, i_pc, 16'h1000 + 16'(k), 8'(k)); end
        end
    endtask

    task automatic test_backpressure;
        int n = 0;
        start(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (imem_rd) n++;
            nxt();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_issues got %0d exp 4", n); end
        checks++; if (imem_rd !== 1'b0 || i_valid !== 1'b1) begin errors++; $display("FAIL bp_full got rd=%b v=%b exp rd=0 v=1", imem_rd, i_valid); end
        i_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) nxt();
            checks++; if (i_valid !== 1'b1 || i_datain !== 16'h1000 + 16'(k) || i_pc !== 8'(k))
                begin errors++; $display("FAIL bp_drain k=%0d got v=%b d=%h pc=%h exp v=1 d=%h", k, i_valid, i_datain, i_pc, 16'h1000 + 16'(k)); end
        end
    endtask

    task automatic test_redirect;
        start(1'b1, 1'b0);
        repeat (4) nxt();
        redirect = 1'b1; redirect_pc = 8'h40;
        #1;
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL redir_noissue got %b exp 0", imem_rd); end
        nxt();
        redirect = 1'b0;
        #1;
        checks++; if (i_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 8'h40 || i_pc !== 8'h40)
            begin errors++; $display("FAIL redir_r1 got v=%b rd=%b addr=%h pc=%h exp v=0 rd=1 addr=40 pc=40", i_valid, imem_rd, imem_addr, i_pc); end
        nxt();
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL redir_r2 got v=%b d=%h exp v=0", i_valid, i_datain); end
        nxt();
        checks++; if (i_valid !== 1'b1 || i_datain !== 16'h1040 || i_pc !== 8'h40)
            begin errors++; $display("FAIL redir_r3 got v=%b d=%h pc=%h exp v=1 d=1040 pc=40", i_valid, i_datain, i_pc); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
        start(1'b1, 1'b1);
        redirect = 1'b1; redirect_pc = 8'hFE;
        nxt();
        redirect = 1'b0;
        nxt();
        for (int k = 0; k < 4; k++) begin
            nxt();
            checks++; if (i_valid !== 1'b1 || i_pc !== exp_pc[k] || i_datain !== 16'h1000 + {8'h00, exp_pc[k]})
                begin errors++; $display("FAIL wrap k=%0d got v=%b pc=%h d=%h exp pc=%h", k, i_valid, i_pc, i_datain, exp_pc[k]); end
        end
    endtask

    task automatic test_enable;
        start(1'b1, 1'b1);
        nxt();
        enable = 1'b0;
        #1;
        checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL en_off_rd got %b exp 0", imem_rd); end
        nxt();
        checks++; if (i_valid !== 1'b1 || i_datain !== 16'h1000 || imem_rd !== 1'b0)
            begin errors++; $display("FAIL en_deliver got v=%b d=%h rd=%b exp v=1 d=1000 rd=0", i_valid, i_datain, imem_rd); end
        nxt();
        checks++; if (i_valid !== 1'b0 || i_datain !== 16'h0000 || i_pc !== 8'h01 || imem_rd !== 1'b0)
            begin errors++; $display("FAIL en_empty got v=%b d=%h pc=%h rd=%b exp v=0 d=0000 pc=01 rd=0", i_valid, i_datain, i_pc, imem_rd); end
    endtask

    task automatic test_reset_mid;
        start(1'b1, 1'b1);
        repeat (4) nxt();
        reset = 1'b1;
        #1;
        checks++; if (i_valid !== 1'b0 || imem_rd !== 1'b0) begin errors++; $display("FAIL rmid_during got v=%b rd=%b exp 0 0", i_valid, imem_rd); end
        nxt();
        reset = 1'b0;
        #1;
        checks++; if (i_valid !== 1'b0 || i_datain !== 16'h0000 || i_pc !== 8'h00 || imem_rd !== 1'b1 || imem_addr !== 8'h00)
            begin errors++; $display("FAIL rmid_after got v=%b d=%h pc=%h rd=%b addr=%h exp 0 0000 00 1 00", i_valid, i_datain, i_pc, imem_rd, imem_addr); end
        nxt();
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got v=%b d=%h exp v=0", i_valid, i_datain); end
        nxt();
        checks++; if (i_valid !== 1'b1 || i_datain !== 16'h1000 || i_pc !== 8'h00)
            begin errors++; $display("FAIL rmid_restart got v=%b d=%h pc=%h exp v=1 d=1000 pc=00", i_valid, i_datain, i_pc); end
    endtask

    task automatic test_redirect_pop;
        start(1'b1, 1'b1);
        repeat (3) nxt();
        redirect = 1'b1; redirect_pc = 8'h80;
        #1;
        checks++; if (i_valid !== 1'b1 || i_datain !== 16'h1001) begin errors++; $display("FAIL rpop_head got v=%b d=%h exp v=1 d=1001", i_valid, i_datain); end
        nxt();
        redirect = 1'b0;
        #1;
        checks++; if (i_valid !== 1'b0 || i_datain !== 16'h0000 || i_pc !== 8'h80)
            begin errors++; $display("FAIL rpop_empty got v=%b d=%h pc=%h exp v=0 d=0000 pc=80", i_valid, i_datain, i_pc); end
        nxt();
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL rpop_r2 got v=%b exp 0", i_valid); end
        nxt();
        checks++; if (i_valid !== 1'b1 || i_datain !== 16'h1080 || i_pc !== 8'h80)
            begin errors++; $display("FAIL rpop_target got v=%b d=%h pc=%h exp v=1 d=1080 pc=80", i_valid, i_datain, i_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_redirect_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
